axis_rr_arbiter: RTL and testbench
==================================

# axis_rr_arbiter

Round-robin, packet-locked arbiter that shares one AXI-Stream output between PORTS input streams. A port holds the grant from its first accepted beat until its beat with tlast, so packets are never interleaved. Every output (m_* and all s_tready bits) is registered, and a two-entry skid stage sustains one beat per clock inside a packet. The block sits in front of any single-consumer datapath stage, for example a register slice or a framer, and feeds it from several producers.

## Interface
- DATA_WIDTH, 8: tdata width in bits.
- PORTS, 4: number of input streams, 2..16.
- ID_WIDTH, 2: width of m_tid; PORTS <= 2**ID_WIDTH is required.
- clock  input  1  the single clock; all logic samples on its rising edge.
- reset_n  input  1  asynchronous, active-low reset; assertion takes effect immediately, release is synchronised externally.
- enable  input  PORTS  per-port arbitration enable (configuration); bit i=0 excludes port i from new grants.
- s_tdata  input  PORTS*DATA_WIDTH  port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- s_tvalid  input  PORTS  per-port valid.
- s_tlast  input  PORTS  per-port end-of-packet.
- s_tready  output  PORTS  per-port ready, registered, at most one bit high (one-hot or zero).
- m_tdata  output  DATA_WIDTH  output data, registered.
- m_tlast  output  1  output end-of-packet, registered.
- m_tid  output  ID_WIDTH  index of the source port of the current output beat, registered.
- m_tvalid  output  1  output valid, registered.
- m_tready  input  1  output ready.

## Operation
- Transfer on any port happens when valid && ready are both high at a rising edge.
- Arbiter FSM has two states: IDLE and LOCKED. It holds grant register g and last-winner register p.
- IDLE: candidates are the ports with s_tvalid[i] && enable[i]. The winner is the first candidate scanning p+1, p+2, … modulo PORTS. If a winner exists, the next edge loads g=winner, moves the FSM to LOCKED and sets s_tready[g]=1 if the skid stage has room. If no candidate exists, the FSM stays in IDLE with all s_tready=0.
- LOCKED: only port g can transfer. On an accepted beat with s_tlast[g]=1, the FSM moves to IDLE, p is loaded with g, and s_tready goes all-zero on the same edge.
- Deasserting enable[g] in the middle of a packet does not break the lock. The packet completes, and the port is excluded from later arbitration.
- s_tvalid dropping in the middle of a packet keeps the lock. The arbiter waits with s_tready[g] still high.
- Output stage behaves as a registered copy stage with a one-entry buffer.
  - m_tvalid <= (m_tvalid && !m_tready) || buffer_full || accept.
  - When the output register is empty or m_tready=1, it loads the buffer if the buffer is full, otherwise the accepted beat.
  - An accepted beat that cannot enter the output register goes into the buffer.
  - s_tready[g] is registered high only when the buffer will be empty next cycle.
- m_tid carries g for each beat; m_tdata, m_tlast and m_tid travel together.
- A beat accepted on m_* is never duplicated, dropped or reordered.

## Timing
- Reset values:
  - s_tready=0, m_tvalid=0, m_tdata=0, m_tlast=0, m_tid=0.
  - FSM=IDLE, buffer empty.
  - p=PORTS-1, so port 0 has highest priority after reset.
- Reset asserted mid-packet aborts it immediately. Data held in the buffer or output register is discarded.
- Latency for the first beat of a packet:
  - valid sampled in IDLE at edge k;
  - s_tready high after edge k;
  - beat accepted at edge k+1;
  - m_tvalid high after edge k+1.
- Within a packet with m_tready=1 held high, throughput is 1 beat/clock.
- Between packets there is exactly one idle (arbitration) cycle. The tlast beat is accepted at edge n, the new grant is made at edge n+1, and the next first beat is accepted at edge n+2 at the earliest.
- Backpressure: after m_tready falls, at most one extra beat is accepted into the buffer, and s_tready[g] is 0 from the following cycle onward.
- Simultaneous requests: resolved strictly by round-robin order from p; no port waits more than PORTS-1 packets.
- A single-beat packet (tlast on its first beat) is legal. The grant returns to IDLE after that one beat.

## Test plan
- Reset, then s_tvalid=4'b1111 with 2-beat packets on every port and m_tready=1 -> m_tid sequence 0,0,1,1,2,2,3,3,0,0, with one bubble cycle between packets and m_tlast on every second beat.
- Port 2 sends a 5-beat packet; port 1 raises valid at the second beat -> all 5 port-2 beats are contiguous on m_*, and port 1 is granted only after the port-2 tlast.
- Single packet 0xA1,0xA2,0xA3 with m_tready toggling 1,0,0,1,1 -> output order A1,A2,A3 exactly once each; s_tready falls after at most one extra accepted beat.
- enable=4'b1010 with all ports valid -> only m_tid 1 and 3 appear, alternating. Clearing enable[1] during a port-1 packet -> that packet completes, then only port 3 is granted.
- reset_n pulsed low in the middle of a packet with m_tvalid=1 -> m_tvalid and all s_tready drop to 0 immediately. After release, port 0 wins the first arbitration.

Source files
------------

// File: rtl/axis_rr_arbiter_if.sv
// AXI-Stream bundle shared by the arbiter and its environment: PORTS input streams, one output stream.
// slave is the arbiter's view; master is the producers' and consumer's view.
interface axis_rr_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int PORTS      = 4,
  parameter int ID_WIDTH   = 2
);
  logic [PORTS*DATA_WIDTH-1:0] s_tdata;
  logic [PORTS-1:0]            s_tvalid;
  logic [PORTS-1:0]            s_tlast;
  logic [PORTS-1:0]            s_tready;
  logic [DATA_WIDTH-1:0]       m_tdata;
  logic                        m_tlast;
  logic [ID_WIDTH-1:0]         m_tid;
  logic                        m_tvalid;
  logic                        m_tready;

  modport slave (
    input  s_tdata, s_tvalid, s_tlast, m_tready,
    output s_tready, m_tdata, m_tlast, m_tid, m_tvalid
  );

  modport master (
    output s_tdata, s_tvalid, s_tlast, m_tready,
    input  s_tready, m_tdata, m_tlast, m_tid, m_tvalid
  );
endinterface

// File: rtl/axis_rr_arbiter.sv
// Round-robin, packet-locked AXI-Stream arbiter; all outputs registered, one-entry skid buffer.
// state     | meaning
// ST_IDLE   | no grant held; picks next enabled, valid port after r_last
// ST_LOCKED | forwarding the packet of r_grant until its tlast beat is accepted
module axis_rr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int PORTS      = 4,
  parameter int ID_WIDTH   = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [PORTS-1:0] enable,
  axis_rr_arbiter_if.slave bus
);
  localparam int IDX_W = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam logic [PORTS-1:0] ONE_HOT0 = {{(PORTS-1){1'b0}}, 1'b1};

  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  state_t                r_state;
  logic [ID_WIDTH-1:0]   r_grant;
  logic [ID_WIDTH-1:0]   r_last;
  logic [PORTS-1:0]      r_s_tready;

  logic                  r_m_tvalid;
  logic [DATA_WIDTH-1:0] r_m_tdata;
  logic                  r_m_tlast;
  logic [ID_WIDTH-1:0]   r_m_tid;

  logic                  r_buf_full;
  logic [DATA_WIDTH-1:0] r_buf_data;
  logic                  r_buf_last;
  logic [ID_WIDTH-1:0]   r_buf_id;

  logic [DATA_WIDTH-1:0] w_port_data [PORTS];
  logic [IDX_W-1:0]      w_gidx;
  logic [DATA_WIDTH-1:0] w_beat_data;
  logic                  w_beat_last;
  logic                  w_accept;
  logic [PORTS-1:0]      w_cand;
  logic                  w_found;
  logic [ID_WIDTH-1:0]   w_winner;
  logic                  w_out_load;
  logic                  w_buf_full_nxt;

  always_comb begin
    for (int i = 0; i < PORTS; i++) begin
      w_port_data[i] = bus.s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign w_gidx      = r_grant[IDX_W-1:0];
  assign w_beat_data = w_port_data[w_gidx];
  assign w_beat_last = bus.s_tlast[w_gidx];
  // r_s_tready is only ever one-hot on the granted port, so any handshake is the granted one
  assign w_accept    = |(bus.s_tvalid & r_s_tready);
  assign w_cand      = bus.s_tvalid & enable;

  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int i = 1; i <= PORTS; i++) begin
      int idx;
      idx = (int'(r_last) + i) % PORTS;
      if (!w_found && w_cand[idx[IDX_W-1:0]]) begin
        w_found  = 1'b1;
        w_winner = ID_WIDTH'(idx);
      end
    end
  end

  assign w_out_load     = !r_m_tvalid || bus.m_tready;
  assign w_buf_full_nxt = !w_out_load && (r_buf_full || w_accept);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_grant    <= '0;
      r_last     <= ID_WIDTH'(PORTS - 1);
      r_s_tready <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_s_tready <= '0;
          if (w_found) begin
            r_grant    <= w_winner;
            r_state    <= ST_LOCKED;
            r_s_tready <= w_buf_full_nxt ? '0 : (ONE_HOT0 << w_winner);
          end
        end
        ST_LOCKED: begin
          if (w_accept && w_beat_last) begin
            r_state    <= ST_IDLE;
            r_last     <= r_grant;
            r_s_tready <= '0;
          end else begin
            r_s_tready <= w_buf_full_nxt ? '0 : (ONE_HOT0 << r_grant);
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_s_tready <= '0;
        end
      endcase
    end
  end

  // Output register refills from the buffer first so beat order is preserved.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_m_tvalid <= 1'b0;
      r_m_tdata  <= '0;
      r_m_tlast  <= 1'b0;
      r_m_tid    <= '0;
      r_buf_full <= 1'b0;
      r_buf_data <= '0;
      r_buf_last <= 1'b0;
      r_buf_id   <= '0;
    end else begin
      r_m_tvalid <= (r_m_tvalid && !bus.m_tready) || r_buf_full || w_accept;
      r_buf_full <= w_buf_full_nxt;
      if (w_out_load) begin
        if (r_buf_full) begin
          r_m_tdata <= r_buf_data;
          r_m_tlast <= r_buf_last;
          r_m_tid   <= r_buf_id;
        end else if (w_accept) begin
          r_m_tdata <= w_beat_data;
          r_m_tlast <= w_beat_last;
          r_m_tid   <= r_grant;
        end
      end else if (w_accept) begin
        r_buf_data <= w_beat_data;
        r_buf_last <= w_beat_last;
        r_buf_id   <= r_grant;
      end
    end
  end

  assign bus.s_tready = r_s_tready;
  assign bus.m_tvalid = r_m_tvalid;
  assign bus.m_tdata  = r_m_tdata;
  assign bus.m_tlast  = r_m_tlast;
  assign bus.m_tid    = r_m_tid;
endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Scoreboard bench for axis_rr_arbiter: per-port packet sources, expected output beats queued up front.
module tb_axis_rr_arbiter;
  localparam int DW = 8;
  localparam int NP = 4;
  localparam int IW = 2;

  logic          clock = 1'b0;
  logic          reset_n;
  logic [NP-1:0] enable;

  axis_rr_arbiter_if #(.DATA_WIDTH(DW), .PORTS(NP), .ID_WIDTH(IW)) bus();

  axis_rr_arbiter #(.DATA_WIDTH(DW), .PORTS(NP), .ID_WIDTH(IW)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .enable (enable),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [IW-1:0] id;
    logic          last;
    logic [DW-1:0] data;
  } beat_t;

  beat_t exp_q[$];
  int    out_cyc[$];
  int    n_checks = 0;
  int    n_errors = 0;
  int    cyc = 0;

  logic [DW-1:0] src_data [NP][16];
  logic          src_last [NP][16];
  int            src_len [NP];
  int            src_idx [NP];
  int            src_start [NP];

  logic          pat [8];
  int            pat_len = 0;
  int            pat_idx = 0;
  logic          mr_default = 1'b1;

  logic [NP-1:0] acc;
  logic          prev_buffered = 1'b0;
  int            run_acc = 0;
  int            max_run_acc = 0;
  int            buffered_cnt = 0;
  int            stall_viol = 0;

  task automatic drive_sources();
    for (int i = 0; i < NP; i++) begin
      if (src_idx[i] < src_len[i] && cyc >= src_start[i]) begin
        bus.s_tvalid[i]          = 1'b1;
        bus.s_tdata[i*DW +: DW]  = src_data[i][src_idx[i]];
        bus.s_tlast[i]           = src_last[i][src_idx[i]];
      end else begin
        bus.s_tvalid[i]          = 1'b0;
        bus.s_tdata[i*DW +: DW]  = '0;
        bus.s_tlast[i]           = 1'b0;
      end
    end
  endtask

  task automatic clear_src();
    for (int i = 0; i < NP; i++) begin
      src_len[i]   = 0;
      src_idx[i]   = 0;
      src_start[i] = 0;
    end
    drive_sources();
  endtask

  task automatic load_pkt(input int port, input int n, input logic [DW-1:0] base);
    for (int j = 0; j < n; j++) begin
      src_data[port][src_len[port]] = base + DW'(j);
      src_last[port][src_len[port]] = (j == n - 1);
      src_len[port]++;
    end
  endtask

  task automatic expect_pkt(input int port, input int n, input logic [DW-1:0] base);
    beat_t b;
    for (int j = 0; j < n; j++) begin
      b.id   = IW'(port);
      b.last = (j == n - 1);
      b.data = base + DW'(j);
      exp_q.push_back(b);
    end
  endtask

  // One clock: observe at the falling edge, then drive the next inputs just after the rising edge.
  task automatic cycle();
    beat_t got;
    beat_t e;
    logic  buffered;
    @(negedge clock);
    for (int i = 0; i < NP; i++) acc[i] = bus.s_tvalid[i] & bus.s_tready[i];
    buffered = (|acc) && bus.m_tvalid && !bus.m_tready;
    if (prev_buffered && bus.s_tready != '0) stall_viol++;
    prev_buffered = buffered;
    if (buffered) buffered_cnt++;
    if (bus.m_tvalid && !bus.m_tready) begin
      if (|acc) run_acc++;
      if (run_acc > max_run_acc) max_run_acc = run_acc;
    end else begin
      run_acc = 0;
    end
    if (bus.m_tvalid && bus.m_tready) begin
      got = {bus.m_tid, bus.m_tlast, bus.m_tdata};
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL scoreboard_extra: got id=%0d last=%0b data=%h, required no beat", got.id, got.last, got.data);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          n_errors++;
          $display("FAIL scoreboard_beat: got id=%0d last=%0b data=%h, required id=%0d last=%0b data=%h",
                   got.id, got.last, got.data, e.id, e.last, e.data);
        end
      end
      out_cyc.push_back(cyc);
    end
    @(posedge clock);
    cyc++;
    #1;
    for (int i = 0; i < NP; i++) if (acc[i]) src_idx[i]++;
    if (pat_idx < pat_len) begin
      bus.m_tready = pat[pat_idx];
      pat_idx++;
    end else begin
      bus.m_tready = mr_default;
    end
    drive_sources();
  endtask

  task automatic wait_drain(input int budget, input string name);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      cycle();
      k++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL %s_drain: %0d beats outstanding after %0d cycles, required 0", name, exp_q.size(), budget);
      exp_q.delete();
    end
    repeat (2) cycle();
  endtask

  task automatic check_gaps(input string name, input int gaps[]);
    n_checks++;
    if (out_cyc.size() != gaps.size() + 1) begin
      n_errors++;
      $display("FAIL %s_count: got %0d output beats, required %0d", name, out_cyc.size(), gaps.size() + 1);
    end
    for (int j = 0; j + 1 < out_cyc.size() && j < gaps.size(); j++) begin
      n_checks++;
      if (out_cyc[j+1] - out_cyc[j] !== gaps[j]) begin
        n_errors++;
        $display("FAIL %s_gap%0d: got spacing %0d cycles, required %0d", name, j, out_cyc[j+1] - out_cyc[j], gaps[j]);
      end
    end
  endtask

  task automatic test_reset();
    reset_n      = 1'b0;
    enable       = '1;
    bus.m_tready = 1'b1;
    clear_src();
    repeat (2) @(posedge clock);
    #1;
    n_checks++;
    if (bus.s_tready !== 4'b0000) begin n_errors++; $display("FAIL reset_s_tready: got %b, required 0000", bus.s_tready); end
    n_checks++;
    if (bus.m_tvalid !== 1'b0) begin n_errors++; $display("FAIL reset_m_tvalid: got %b, required 0", bus.m_tvalid); end
    n_checks++;
    if (bus.m_tdata !== 8'h00) begin n_errors++; $display("FAIL reset_m_tdata: got %h, required 00", bus.m_tdata); end
    n_checks++;
    if (bus.m_tlast !== 1'b0) begin n_errors++; $display("FAIL reset_m_tlast: got %b, required 0", bus.m_tlast); end
    n_checks++;
    if (bus.m_tid !== 2'd0) begin n_errors++; $display("FAIL reset_m_tid: got %0d, required 0", bus.m_tid); end
    reset_n = 1'b1;
    repeat (3) cycle();
    n_checks++;
    if (bus.s_tready !== 4'b0000 || bus.m_tvalid !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_idle: got s_tready=%b m_tvalid=%b, required 0000 and 0", bus.s_tready, bus.m_tvalid);
    end
  endtask

  task automatic test_round_robin();
    clear_src();
    out_cyc.delete();
    load_pkt(0, 2, 8'h00);
    load_pkt(0, 2, 8'h02);
    load_pkt(1, 2, 8'h10);
    load_pkt(2, 2, 8'h20);
    load_pkt(3, 2, 8'h30);
    expect_pkt(0, 2, 8'h00);
    expect_pkt(1, 2, 8'h10);
    expect_pkt(2, 2, 8'h20);
    expect_pkt(3, 2, 8'h30);
    expect_pkt(0, 2, 8'h02);
    drive_sources();
    wait_drain(80, "rr");
    check_gaps("rr", '{1, 2, 1, 2, 1, 2, 1, 2, 1});
  endtask

  task automatic test_packet_lock();
    clear_src();
    out_cyc.delete();
    load_pkt(2, 5, 8'h50);
    load_pkt(1, 2, 8'h60);
    src_start[1] = cyc + 2;
    expect_pkt(2, 5, 8'h50);
    expect_pkt(1, 2, 8'h60);
    drive_sources();
    wait_drain(60, "lock");
    check_gaps("lock", '{1, 1, 1, 1, 2, 1});
  endtask

  task automatic test_backpressure();
    clear_src();
    out_cyc.delete();
    load_pkt(0, 3, 8'hA1);
    expect_pkt(0, 3, 8'hA1);
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1; pat[4] = 1'b1;
    pat_len = 5;
    pat_idx = 0;
    max_run_acc = 0; run_acc = 0; buffered_cnt = 0; stall_viol = 0; prev_buffered = 1'b0;
    drive_sources();
    wait_drain(40, "bp");
    pat_len = 0;
    n_checks++;
    if (max_run_acc > 1) begin n_errors++; $display("FAIL bp_extra_beats: got %0d beats accepted during stall, required at most 1", max_run_acc); end
    n_checks++;
    if (buffered_cnt !== 1) begin n_errors++; $display("FAIL bp_buffered: got %0d beats into skid buffer, required 1", buffered_cnt); end
    n_checks++;
    if (stall_viol !== 0) begin n_errors++; $display("FAIL bp_ready_drop: got %0d cycles with s_tready high after a buffered beat, required 0", stall_viol); end
  endtask

  task automatic test_enable();
    logic bad;
    int   k;
    clear_src();
    enable = 4'b1010;
    load_pkt(0, 2, 8'h70);
    load_pkt(1, 2, 8'h80);
    load_pkt(1, 2, 8'h82);
    load_pkt(2, 2, 8'h90);
    load_pkt(3, 2, 8'hB0);
    load_pkt(3, 2, 8'hB2);
    expect_pkt(1, 2, 8'h80);
    expect_pkt(3, 2, 8'hB0);
    expect_pkt(1, 2, 8'h82);
    expect_pkt(3, 2, 8'hB2);
    drive_sources();
    wait_drain(80, "enable_alt");
    bad = 1'b0;
    repeat (4) begin
      cycle();
      if (bus.s_tready != '0 || bus.m_tvalid) bad = 1'b1;
    end
    n_checks++;
    if (bad !== 1'b0) begin n_errors++; $display("FAIL enable_disabled_idle: got activity flag %b with only disabled ports valid, required 0", bad); end

    clear_src();
    load_pkt(1, 3, 8'hC0);
    load_pkt(1, 2, 8'hC3);
    load_pkt(3, 2, 8'hD0);
    load_pkt(3, 2, 8'hD2);
    expect_pkt(1, 3, 8'hC0);
    expect_pkt(3, 2, 8'hD0);
    expect_pkt(3, 2, 8'hD2);
    drive_sources();
    k = 0;
    while (src_idx[1] < 1 && k < 10) begin
      cycle();
      k++;
    end
    n_checks++;
    if (src_idx[1] < 1) begin n_errors++; $display("FAIL enable_first_beat: got %0d port-1 beats accepted in 10 cycles, required 1", src_idx[1]); end
    enable = 4'b1000;
    wait_drain(80, "enable_drop");
    bad = 1'b0;
    repeat (6) begin
      cycle();
      if (bus.s_tready[1] || bus.m_tvalid) bad = 1'b1;
    end
    n_checks++;
    if (bad !== 1'b0) begin n_errors++; $display("FAIL enable_excluded: got activity flag %b for disabled port 1, required 0", bad); end
    n_checks++;
    if (src_idx[1] !== 3) begin n_errors++; $display("FAIL enable_pending: got %0d port-1 beats taken, required 3", src_idx[1]); end
    clear_src();
    enable = '1;
  endtask

  task automatic test_reset_mid_packet();
    int k;
    clear_src();
    mr_default   = 1'b0;
    bus.m_tready = 1'b0;
    load_pkt(0, 5, 8'hE0);
    drive_sources();
    k = 0;
    while (!(bus.m_tvalid && bus.s_tready != '0) && k < 10) begin
      cycle();
      k++;
    end
    n_checks++;
    if (!(bus.m_tvalid && bus.s_tready != '0)) begin
      n_errors++;
      $display("FAIL rstmid_setup: got m_tvalid=%b s_tready=%b, required 1 and nonzero", bus.m_tvalid, bus.s_tready);
    end
    #3;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (bus.m_tvalid !== 1'b0) begin n_errors++; $display("FAIL rstmid_m_tvalid: got %b, required 0", bus.m_tvalid); end
    n_checks++;
    if (bus.s_tready !== 4'b0000) begin n_errors++; $display("FAIL rstmid_s_tready: got %b, required 0000", bus.s_tready); end
    n_checks++;
    if (bus.m_tdata !== 8'h00) begin n_errors++; $display("FAIL rstmid_m_tdata: got %h, required 00", bus.m_tdata); end
    clear_src();
    exp_q.delete();
    mr_default   = 1'b1;
    bus.m_tready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;

    load_pkt(3, 1, 8'hF3);
    load_pkt(1, 1, 8'hF1);
    load_pkt(0, 1, 8'hF0);
    expect_pkt(0, 1, 8'hF0);
    expect_pkt(1, 1, 8'hF1);
    expect_pkt(3, 1, 8'hF3);
    drive_sources();
    cycle();
    n_checks++;
    if (bus.s_tready !== 4'b0001) begin n_errors++; $display("FAIL rstmid_first_grant: got s_tready=%b, required 0001", bus.s_tready); end
    cycle();
    n_checks++;
    if (bus.m_tvalid !== 1'b1 || bus.m_tid !== 2'd0) begin
      n_errors++;
      $display("FAIL rstmid_first_beat: got m_tvalid=%b m_tid=%0d, required 1 and 0", bus.m_tvalid, bus.m_tid);
    end
    wait_drain(30, "after_reset");
  endtask

  initial begin
    bus.s_tdata  = '0;
    bus.s_tvalid = '0;
    bus.s_tlast  = '0;
    bus.m_tready = 1'b1;
    enable       = '1;
    reset_n      = 1'b0;
    test_reset();
    test_round_robin();
    test_packet_lock();
    test_backpressure();
    test_enable();
    test_reset_mid_packet();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
